// File: rtl/mdu_div_if.sv
// EX-stage <-> divider handshake bundle: operands and start/annul in, 64-bit {rem, quot} result and ready out.
// start_i is held high by EX while it waits; ready_o stays high until start_i drops, so the result is taken while both are high.
interface mdu_div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/mdu_div.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU; result {remainder, quotient} with a ready flag.
// Optional macro DIV_BYZERO_FAST_EN: short-cuts a zero divisor through DivByZero in one edge.
module mdu_div (
    input  logic           clk,
    input  logic           rst,
    mdu_div_if.slave       bus,
    output logic [1:0]     o_dbg_state
);

    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
`ifdef DIV_BYZERO_FAST_EN
        DIV_BYZERO = 2'd1,
`endif
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_dividend;
    logic [31:0] r_divisor;
    logic [31:0] r_op1_raw;
    logic        r_sign1;
    logic        r_sign2;
    logic        r_zero;
    logic [63:0] r_result;
    logic        r_ready;

    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [33:0] w_diff;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign w_mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

    // Trial subtract on the partial remainder after the left shift; bit 33 is the borrow.
    assign w_diff = r_dividend[64:31] - {2'b00, r_divisor};

    assign w_quot_fix = (r_sign1 ^ r_sign2) ? (~r_dividend[31:0] + 32'd1) : r_dividend[31:0];
    assign w_rem_fix  = r_sign1 ? (~r_dividend[63:32] + 32'd1) : r_dividend[63:32];

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
    assign o_dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_FREE;
            r_cnt      <= 6'd0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_op1_raw  <= '0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_zero     <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        r_dividend <= {33'd0, w_mag1};
                        r_divisor  <= w_mag2;
                        r_op1_raw  <= bus.opdata1_i;
                        r_sign1    <= bus.signed_div_i & bus.opdata1_i[31];
                        r_sign2    <= bus.signed_div_i & bus.opdata2_i[31];
                        r_zero     <= (bus.opdata2_i == 32'd0);
                        r_cnt      <= 6'd0;
`ifdef DIV_BYZERO_FAST_EN
                        r_state    <= (bus.opdata2_i == 32'd0) ? DIV_BYZERO : DIV_ON;
`else
                        r_state    <= DIV_ON;
`endif
                    end
                end
`ifdef DIV_BYZERO_FAST_EN
                DIV_BYZERO: begin
                    if (bus.annul_i) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_result <= {r_op1_raw, 32'hFFFF_FFFF};
                        r_ready  <= 1'b1;
                        r_state  <= DIV_END;
                    end
                end
`endif
                DIV_ON: begin
                    if (bus.annul_i) begin
                        r_state <= DIV_FREE;
                        r_cnt   <= 6'd0;
                    end else if (r_cnt == 6'd32) begin
                        // A zero divisor ran the full loop; its result is forced, not sign-corrected.
                        r_result <= r_zero ? {r_op1_raw, 32'hFFFF_FFFF} : {w_rem_fix, w_quot_fix};
                        r_ready  <= 1'b1;
                        r_state  <= DIV_END;
                    end else begin
                        if (w_diff[33]) begin
                            r_dividend <= {r_dividend[63:0], 1'b0};
                        end else begin
                            r_dividend <= {w_diff[32:0], r_dividend[30:0], 1'b1};
                        end
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                DIV_END: begin
                    if (!bus.start_i) begin
                        r_state  <= DIV_FREE;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

endmodule
